// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Latency: none (types, constants and helper functions only).
// Backpressure: not applicable.
package serial_arith_pkg;

  // Control FSM encodings shared by the serial arithmetic units
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2 for sizing counters; bounded loop keeps it elaboration-friendly
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow out when y exceeds x, or when they are equal and a borrow comes in
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first through one full-subtractor cell.
// Latency: start accepted at edge T, done pulses in cycle T+WIDTH+1, ready again at T+WIDTH+2.
// Backpressure: ready low during RUN and DONE; starts seen while not ready are dropped.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  // One extra bit so the counter can never wrap before the last bit is handled
  localparam int CW = clog2(WIDTH) + 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_count;
  logic             r_borrow;
  logic             r_borrow_out;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor_bit u_fs (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_last     = (r_count == CW'(WIDTH - 1));
  assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};

  // Control FSM plus datapath; outputs are registered so the final result is
  // already visible in the cycle where done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res_sh     <= '0;
      r_diff       <= '0;
      r_count      <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start && r_ready) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= 1'b0;
            r_count  <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_borrow <= w_bo;
          r_count  <= r_count + CW'(1);
          if (w_last) begin
            // Last bit: publish the completed result together with done
            r_diff       <= w_res_next;
            r_borrow_out <= w_bo;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8).
// Directed handshake/reset cases, then randomized operands against plain a - b arithmetic.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven there too.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready      (ready),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: modular difference and unsigned compare
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    return W'(x - y);
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y);
  endfunction

  // Issue one operation from IDLE; returns result, done latency and hold check.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        output logic [W-1:0] got_d, output logic got_bo,
                        output int lat, output logic held);
    logic [W-1:0] prev;
    prev  = diff;
    held  = 1'b1;
    start = 1'b1;
    a     = xa;
    b     = xb;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    lat   = 1;
    while (!done && lat < 20) begin
      if (diff !== prev) held = 1'b0;
      tick();
      lat++;
    end
    got_d  = diff;
    got_bo = borrow_out;
    tick();
  endtask

  logic [W-1:0] rd;
  logic         rb;
  logic         hold;
  int           lat;

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bo", borrow_out, 0);

    // Basic op with latency and status checks
    start = 1'b1; a = 8'h5A; b = 8'h3C;
    tick();
    start = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_ready", ready, 0);
    lat = 1;
    while (!done && lat < 20) begin tick(); lat++; end
    chk("lat_5a3c", lat, W + 1);
    chk("diff_5a3c", diff, 8'h1E);
    chk("bo_5a3c", borrow_out, 0);
    chk("done_busy", busy, 0);
    chk("done_ready", ready, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("ready_back", ready, 1);
    chk("diff_hold_idle", diff, 8'h1E);

    // Borrow generated, then cleared for the next op
    run_op(8'h00, 8'h01, rd, rb, lat, hold);
    chk("diff_0001", rd, 8'hFF);
    chk("bo_0001", rb, 1);
    run_op(8'hFF, 8'hFF, rd, rb, lat, hold);
    chk("diff_ffff", rd, 8'h00);
    chk("bo_ffff", rb, 0);
    chk("hold_ffff", hold, 1);

    // Starts while busy are ignored
    begin
      int n_done = 0;
      int done_cyc = -1;
      int rdy_cyc = -1;
      start = 1'b1; a = 8'h80; b = 8'h01;
      tick();
      for (int c = 1; c <= 14; c++) begin
        if (done) begin n_done++; done_cyc = c; end
        if (ready && rdy_cyc < 0) rdy_cyc = c;
        start = (c == 3 || c == 9);
        if (start) begin a = 8'h11; b = 8'h11; end
        tick();
      end
      start = 1'b0;
      chk("ign_ndone", n_done, 1);
      chk("ign_done_cyc", done_cyc, 9);
      chk("ign_ready_cyc", rdy_cyc, 10);
      chk("ign_diff", diff, 8'h7F);
      chk("ign_bo", borrow_out, 0);
    end

    // Reset in the middle of RUN aborts the op
    begin
      int n_done = 0;
      start = 1'b1; a = 8'h10; b = 8'h20;
      tick();
      start = 1'b0;
      for (int c = 1; c < 4; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_ready", ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_diff", diff, 0);
      chk("abort_bo", borrow_out, 0);
      for (int c = 0; c < 12; c++) begin
        if (done) n_done++;
        tick();
      end
      chk("abort_nodone", n_done, 0);
      run_op(8'h10, 8'h20, rd, rb, lat, hold);
      chk("diff_1020", rd, 8'hF0);
      chk("bo_1020", rb, 1);
    end

    // start and rst together: reset wins
    start = 1'b1; rst = 1'b1; a = 8'h33; b = 8'h11;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rststart_busy", busy, 0);
    chk("rststart_ready", ready, 1);

    // Back-to-back with start held high
    begin
      int d1 = -1, d2 = -1;
      logic [W-1:0] r1 = '0, r2 = '0;
      logic b1 = 1'b0, b2 = 1'b0;
      logic stable = 1'b1;
      start = 1'b1; a = 8'h05; b = 8'h03;
      tick();
      a = 8'h03; b = 8'h05;
      for (int c = 1; c <= 20; c++) begin
        if (done && d1 < 0) begin d1 = c; r1 = diff; b1 = borrow_out; end
        else if (done && d2 < 0) begin d2 = c; r2 = diff; b2 = borrow_out; end
        else if (d1 > 0 && d2 < 0 && diff !== r1) stable = 1'b0;
        tick();
      end
      start = 1'b0;
      tick();
      tick();
      while (!ready) tick();
      chk("b2b_done1", d1, 9);
      chk("b2b_done2", d2, 19);
      chk("b2b_diff1", r1, 8'h02);
      chk("b2b_bo1", b1, 0);
      chk("b2b_diff2", r2, 8'hFE);
      chk("b2b_bo2", b2, 1);
      chk("b2b_stable", stable, 1);
    end

    // Randomized operations including corner values
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] ra, rbv;
      int sel;
      sel = $urandom_range(0, 5);
      ra  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h80 : W'($urandom);
      sel = $urandom_range(0, 5);
      rbv = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'h80 : W'($urandom);
      run_op(ra, rbv, rd, rb, lat, hold);
      chk("rnd_diff", rd, ref_diff(ra, rbv));
      chk("rnd_bo", rb, ref_borrow(ra, rbv));
      chk("rnd_lat", lat, W + 1);
      chk("rnd_hold", hold, 1);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
